cop0_unit: RTL

//  Coprocessor-0 and exception sequencer. It consumes the decoder's exc_ri/exc_sys/exc_ret/cowrite

---
 rtl/cop0_if.sv | 33 +++
 rtl/cop0_unit.sv | 95 +++++++++
 2 files changed

// File: rtl/cop0_if.sv
// cop0_if: commit-point flags, CP0 access and redirect/flush signals between pipeline and cop0_unit
interface cop0_if;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        exc_ri;
    logic        exc_sys;
    logic        exc_ret;
    logic        exc_ov;
    logic        exc_adr;
    logic [31:0] bad_vaddr;
    logic        irq;
    logic        cowrite;
    logic [4:0]  co_addr;
    logic [31:0] co_wdata;
    logic [4:0]  co_raddr;
    logic [31:0] co_rdata;
    logic        cpu_mode;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;

    modport master (
        output commit_valid, commit_pc, exc_ri, exc_sys, exc_ret, exc_ov, exc_adr, bad_vaddr,
               irq, cowrite, co_addr, co_wdata, co_raddr,
        input  co_rdata, cpu_mode, redirect, redirect_pc, flush
    );

    modport slave (
        input  commit_valid, commit_pc, exc_ri, exc_sys, exc_ret, exc_ov, exc_adr, bad_vaddr,
               irq, cowrite, co_addr, co_wdata, co_raddr,
        output co_rdata, cpu_mode, redirect, redirect_pc, flush
    );
endinterface

// File: rtl/cop0_unit.sv
// cop0_unit: CP0 registers plus exception/eret sequencer driving pipeline redirect and flush
module cop0_unit #(
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
    parameter int unsigned FLUSH_CYCLES = 3,
    parameter logic [31:0] RESET_STATUS = 32'h0000_0002
) (
    input logic   clk,
    input logic   reset,
    cop0_if.slave bus
);
    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t      state;
    logic [31:0] status;
    logic [31:0] epc;
    logic [31:0] bad_vaddr_r;
    logic [4:0]  exc_code;
    logic [1:0]  sw_ip;
    logic [3:0]  cnt;
    logic        redirect_r;
    logic [31:0] redirect_pc_r;
    logic        flush_r;
    logic        go;
    logic        intr;
    logic        take_exc;
    logic        take_ret;
    logic        take_wr;
    logic [4:0]  code;
    logic [31:0] cause;

    assign go       = state == RUN && bus.commit_valid;
    assign intr     = bus.irq && status[0] && !status[1];
    assign take_exc = go && (bus.exc_adr || bus.exc_ri || bus.exc_sys || bus.exc_ov || intr);
    assign take_ret = go && !take_exc && bus.exc_ret && status[1];
    assign take_wr  = go && !take_exc && !take_ret && bus.cowrite;
    assign code     = bus.exc_adr ? 5'd4 : bus.exc_ri ? 5'd10 : bus.exc_sys ? 5'd8 :
                      bus.exc_ov ? 5'd12 : 5'd0;
    // IP2 is the live irq line, not a stored bit
    assign cause    = {21'b0, bus.irq, sw_ip, 1'b0, exc_code, 2'b0};

    assign bus.co_rdata    = bus.co_raddr == 5'd8  ? bad_vaddr_r :
                             bus.co_raddr == 5'd12 ? status :
                             bus.co_raddr == 5'd13 ? cause :
                             bus.co_raddr == 5'd14 ? epc : 32'h0;
    assign bus.cpu_mode    = status[1];
    assign bus.redirect    = redirect_r;
    assign bus.redirect_pc = redirect_pc_r;
    assign bus.flush       = flush_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= RUN;
            status        <= RESET_STATUS;
            epc           <= 32'h0;
            bad_vaddr_r   <= 32'h0;
            exc_code      <= 5'd0;
            sw_ip         <= 2'd0;
            cnt           <= 4'd0;
            redirect_r    <= 1'b0;
            redirect_pc_r <= 32'h0;
            flush_r       <= 1'b0;
        end else if (state == RUN) begin
            if (take_exc) begin
                exc_code      <= code;
                status[1]     <= 1'b1;
                redirect_pc_r <= EXC_VECTOR;
                if (!status[1]) epc <= bus.commit_pc;
                if (bus.exc_adr) bad_vaddr_r <= bus.bad_vaddr;
            end else if (take_ret) begin
                status[1]     <= 1'b0;
                redirect_pc_r <= epc;
            end else if (take_wr) begin
                if (bus.co_addr == 5'd12) status <= bus.co_wdata;
                if (bus.co_addr == 5'd13) sw_ip <= bus.co_wdata[9:8];
                if (bus.co_addr == 5'd14) epc <= bus.co_wdata;
            end
            if (take_exc || take_ret) begin
                state      <= FLUSH;
                redirect_r <= 1'b1;
                flush_r    <= 1'b1;
                cnt        <= FLUSH_LAST;
            end
        end else begin
            redirect_r <= 1'b0;
            if (cnt == 4'd0) begin
                state   <= RUN;
                flush_r <= 1'b0;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end
endmodule
